// File: rtl/alu_opnd_stage_pkg.sv
// rtl/alu_opnd_stage_pkg.sv - command encodings, FSM states and operand-need decode for the ALU operand stage
//
// Package alu_pkg
//   Command encodings for arithmetic (MODE=1) and logical (MODE=0) modes,
//   FSM state enum, and need_ops() which maps (mode, cmd) to the required
//   operand mask {OPB, OPA} plus an illegal-command flag.
package alu_pkg;

  // Arithmetic mode (MODE=1)
  localparam logic [3:0] A_ADD     = 4'd0;
  localparam logic [3:0] A_SUB     = 4'd1;
  localparam logic [3:0] A_ADD_CIN = 4'd2;
  localparam logic [3:0] A_SUB_CIN = 4'd3;
  localparam logic [3:0] A_INC_A   = 4'd4;
  localparam logic [3:0] A_DEC_A   = 4'd5;
  localparam logic [3:0] A_INC_B   = 4'd6;
  localparam logic [3:0] A_DEC_B   = 4'd7;
  localparam logic [3:0] A_CMP     = 4'd8;
  localparam logic [3:0] A_MUL_INC = 4'd9;
  localparam logic [3:0] A_MUL_SHL = 4'd10;

  // Logical mode (MODE=0)
  localparam logic [3:0] L_AND     = 4'd0;
  localparam logic [3:0] L_NAND    = 4'd1;
  localparam logic [3:0] L_OR      = 4'd2;
  localparam logic [3:0] L_NOR     = 4'd3;
  localparam logic [3:0] L_XOR     = 4'd4;
  localparam logic [3:0] L_XNOR    = 4'd5;
  localparam logic [3:0] L_NOT_A   = 4'd6;
  localparam logic [3:0] L_NOT_B   = 4'd7;
  localparam logic [3:0] L_SHR1_A  = 4'd8;
  localparam logic [3:0] L_SHL1_A  = 4'd9;
  localparam logic [3:0] L_SHR1_B  = 4'd10;
  localparam logic [3:0] L_SHL1_B  = 4'd11;
  localparam logic [3:0] L_ROL_A_B = 4'd12;
  localparam logic [3:0] L_ROR_A_B = 4'd13;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0] need;     // bit0 = OPA required, bit1 = OPB required
    logic       illegal;
  } need_t;

  function automatic need_t need_ops(input logic mode, input logic [3:0] cmd);
    need_t r;
    r.need    = 2'b00;
    r.illegal = 1'b0;
    if (mode) begin
      case (cmd)
        A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN,
        A_CMP, A_MUL_INC, A_MUL_SHL:          r.need = 2'b11;
        A_INC_A, A_DEC_A:                     r.need = 2'b01;
        A_INC_B, A_DEC_B:                     r.need = 2'b10;
        default:                              r.illegal = 1'b1;
      endcase
    end else begin
      case (cmd)
        L_AND, L_NAND, L_OR, L_NOR, L_XOR,
        L_XNOR, L_ROL_A_B, L_ROR_A_B:         r.need = 2'b11;
        L_NOT_A, L_SHR1_A, L_SHL1_A:          r.need = 2'b01;
        L_NOT_B, L_SHR1_B, L_SHL1_B:          r.need = 2'b10;
        default:                              r.illegal = 1'b1;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_opnd_stage_if.sv
// rtl/alu_opnd_stage_if.sv - bus-side and ALU-side signal bundle of the operand stage
//
// Interface alu_opnd_stage_if #(WIDTH, CWIDTH)
//   Inputs to the stage : OPA, OPB, CMD, MODE, CIN, CE, INP_VALID
//   Outputs of the stage: O_OPA, O_OPB, O_CMD, O_MODE, O_CIN, O_VALID, O_ERR, O_WAIT
//   master: the upstream driver (drives inputs, observes outputs)
//   slave : the operand stage itself
interface alu_opnd_stage_if #(
  parameter int WIDTH  = 8,
  parameter int CWIDTH = 4
);
  logic [WIDTH-1:0]  OPA;
  logic [WIDTH-1:0]  OPB;
  logic [CWIDTH-1:0] CMD;
  logic              MODE;
  logic              CIN;
  logic              CE;
  logic [1:0]        INP_VALID;

  logic [WIDTH-1:0]  O_OPA;
  logic [WIDTH-1:0]  O_OPB;
  logic [CWIDTH-1:0] O_CMD;
  logic              O_MODE;
  logic              O_CIN;
  logic              O_VALID;
  logic              O_ERR;
  logic              O_WAIT;

  modport master (
    output OPA, OPB, CMD, MODE, CIN, CE, INP_VALID,
    input  O_OPA, O_OPB, O_CMD, O_MODE, O_CIN, O_VALID, O_ERR, O_WAIT
  );

  modport slave (
    input  OPA, OPB, CMD, MODE, CIN, CE, INP_VALID,
    output O_OPA, O_OPB, O_CMD, O_MODE, O_CIN, O_VALID, O_ERR, O_WAIT
  );
endinterface

// File: rtl/alu_opnd_stage_decode.sv
// rtl/alu_opnd_stage_decode.sv - combinational (mode, cmd) to need-mask/illegal decoder
//
// Module alu_opnd_decode #(CWIDTH)
//   mode    in  1      : 1 = arithmetic, 0 = logical
//   cmd     in  CWIDTH : command
//   need    out 2      : required operands, bit0 = OPA, bit1 = OPB
//   illegal out 1      : command not defined for this mode
module alu_opnd_decode
  import alu_pkg::*;
#(
  parameter int CWIDTH = 4
) (
  input  logic              mode,
  input  logic [CWIDTH-1:0] cmd,
  output logic [1:0]        need,
  output logic              illegal
);

  logic [31:0] cmd_ext;
  need_t       dec;

  // Encodings only occupy 4 bits; anything above 15 on a wider bus is illegal.
  always_comb begin
    cmd_ext = 32'(cmd);
    dec     = need_ops(mode, cmd_ext[3:0]);
    illegal = dec.illegal | (cmd_ext > 32'd15);
    need    = illegal ? 2'b00 : dec.need;
  end

endmodule

// File: rtl/alu_opnd_stage.sv
// rtl/alu_opnd_stage.sv - operand-collection stage that issues fully formed operations to the ALU core
//
// Module alu_opnd_stage #(WIDTH, CWIDTH, TIMEOUT)
//   CLK in  : clock
//   RST in  : synchronous active-high reset
//   bus     : alu_opnd_stage_if.slave
//             in : OPA, OPB, CMD, MODE, CIN, CE, INP_VALID
//             out: O_OPA, O_OPB, O_CMD, O_MODE, O_CIN (hold between issues),
//                  O_VALID (one-cycle issue), O_ERR (timeout/illegal), O_WAIT
module alu_opnd_stage
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CWIDTH  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             RST,
  alu_opnd_stage_if.slave  bus
);

  localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0] need;
  logic       illegal;

  alu_opnd_decode #(.CWIDTH(CWIDTH)) u_decode (
    .mode    (bus.MODE),
    .cmd     (bus.CMD),
    .need    (need),
    .illegal (illegal)
  );

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  // Held command while waiting; the missing operand's hold slot stays 0 so a
  // timeout issue can use the hold registers directly.
  logic [CWIDTH-1:0] h_cmd, h_cmd_nxt;
  logic              h_mode, h_mode_nxt;
  logic              h_cin, h_cin_nxt;
  logic [WIDTH-1:0]  h_opa, h_opa_nxt;
  logic [WIDTH-1:0]  h_opb, h_opb_nxt;
  logic [1:0]        h_miss, h_miss_nxt;

  logic [WIDTH-1:0]  o_opa, o_opa_nxt;
  logic [WIDTH-1:0]  o_opb, o_opb_nxt;
  logic [CWIDTH-1:0] o_cmd, o_cmd_nxt;
  logic              o_mode, o_mode_nxt;
  logic              o_cin, o_cin_nxt;
  logic              o_valid, o_valid_nxt;
  logic              o_err, o_err_nxt;
  logic              o_wait, o_wait_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      h_cmd   <= '0;
      h_mode  <= 1'b0;
      h_cin   <= 1'b0;
      h_opa   <= '0;
      h_opb   <= '0;
      h_miss  <= 2'b00;
      o_opa   <= '0;
      o_opb   <= '0;
      o_cmd   <= '0;
      o_mode  <= 1'b0;
      o_cin   <= 1'b0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      o_wait  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      h_cmd   <= h_cmd_nxt;
      h_mode  <= h_mode_nxt;
      h_cin   <= h_cin_nxt;
      h_opa   <= h_opa_nxt;
      h_opb   <= h_opb_nxt;
      h_miss  <= h_miss_nxt;
      o_opa   <= o_opa_nxt;
      o_opb   <= o_opb_nxt;
      o_cmd   <= o_cmd_nxt;
      o_mode  <= o_mode_nxt;
      o_cin   <= o_cin_nxt;
      o_valid <= o_valid_nxt;
      o_err   <= o_err_nxt;
      o_wait  <= o_wait_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    h_cmd_nxt   = h_cmd;
    h_mode_nxt  = h_mode;
    h_cin_nxt   = h_cin;
    h_opa_nxt   = h_opa;
    h_opb_nxt   = h_opb;
    h_miss_nxt  = h_miss;
    o_opa_nxt   = o_opa;
    o_opb_nxt   = o_opb;
    o_cmd_nxt   = o_cmd;
    o_mode_nxt  = o_mode;
    o_cin_nxt   = o_cin;
    o_valid_nxt = 1'b0;
    o_err_nxt   = 1'b0;

    if (bus.CE) begin
      case (state)
        ST_IDLE: begin
          if (illegal) begin
            o_valid_nxt = 1'b1;
            o_err_nxt   = 1'b1;
            o_opa_nxt   = '0;
            o_opb_nxt   = '0;
            o_cmd_nxt   = bus.CMD;
            o_mode_nxt  = bus.MODE;
            o_cin_nxt   = bus.CIN;
          end else if (bus.INP_VALID == 2'b00) begin
            // bus idle
          end else if ((bus.INP_VALID & need) == need) begin
            o_valid_nxt = 1'b1;
            o_opa_nxt   = need[0] ? bus.OPA : '0;
            o_opb_nxt   = need[1] ? bus.OPB : '0;
            o_cmd_nxt   = bus.CMD;
            o_mode_nxt  = bus.MODE;
            o_cin_nxt   = bus.CIN;
          end else begin
            state_nxt  = ST_WAIT;
            cnt_nxt    = '0;
            h_cmd_nxt  = bus.CMD;
            h_mode_nxt = bus.MODE;
            h_cin_nxt  = bus.CIN;
            h_opa_nxt  = (need[0] & bus.INP_VALID[0]) ? bus.OPA : '0;
            h_opb_nxt  = (need[1] & bus.INP_VALID[1]) ? bus.OPB : '0;
            h_miss_nxt = need & ~bus.INP_VALID;
          end
        end

        ST_WAIT: begin
          // Arrival is checked first so it wins over the timeout edge.
          if ((bus.INP_VALID & h_miss) != 2'b00) begin
            o_valid_nxt = 1'b1;
            o_opa_nxt   = h_miss[0] ? bus.OPA : h_opa;
            o_opb_nxt   = h_miss[1] ? bus.OPB : h_opb;
            o_cmd_nxt   = h_cmd;
            o_mode_nxt  = h_mode;
            o_cin_nxt   = h_cin;
            state_nxt   = ST_IDLE;
            cnt_nxt     = '0;
          end else if (cnt == CNT_LAST) begin
            o_valid_nxt = 1'b1;
            o_err_nxt   = 1'b1;
            o_opa_nxt   = h_opa;
            o_opb_nxt   = h_opb;
            o_cmd_nxt   = h_cmd;
            o_mode_nxt  = h_mode;
            o_cin_nxt   = h_cin;
            state_nxt   = ST_IDLE;
            cnt_nxt     = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end

        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    o_wait_nxt = (state_nxt == ST_WAIT);
  end

  assign bus.O_OPA   = o_opa;
  assign bus.O_OPB   = o_opb;
  assign bus.O_CMD   = o_cmd;
  assign bus.O_MODE  = o_mode;
  assign bus.O_CIN   = o_cin;
  assign bus.O_VALID = o_valid;
  assign bus.O_ERR   = o_err;
  assign bus.O_WAIT  = o_wait;

endmodule
